// File: rtl/led_fader_pkg.sv
`default_nettype none
// ============================================================================
// Module  : led_fader_pkg
// Brief   : Mode and direction encodings shared by the LED fader blocks.
// Revision: 1.0 - initial release
// ============================================================================
package led_fader_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_ON      = 2'b01,
        MODE_BLINK   = 2'b10,
        MODE_BREATHE = 2'b11
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

endpackage : led_fader_pkg
`default_nettype wire

// File: rtl/led_fader_chan.sv
`default_nettype none
// ============================================================================
// Module  : led_fader_chan
// Brief   : One LED channel: mode latch, duty/direction state, PWM compare.
// Revision: 1.0 - initial release
// ============================================================================
module led_fader_chan
    import led_fader_pkg::*;
#(
    parameter int P_PWM_BITS = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_period_end,
    input  logic                  i_step,
    input  logic [P_PWM_BITS-1:0] i_pwm,
    input  logic [1:0]            i_mode,
    input  logic [P_PWM_BITS-1:0] i_level,
    input  logic                  i_en,
    output logic                  o_led
);

    mode_e                 r_mode;
    dir_e                  r_dir;
    logic [P_PWM_BITS-1:0] r_duty;
    logic                  r_led;

    mode_e                 w_mode_in;
    dir_e                  w_dir_nxt;
    logic [P_PWM_BITS-1:0] w_duty_nxt;

    assign w_mode_in = mode_e'(i_mode);

    // A freshly selected mode always restarts from duty 0 rising, even on a step.
    always_comb begin
        w_duty_nxt = r_duty;
        w_dir_nxt  = r_dir;
        if (w_mode_in != r_mode) begin
            w_duty_nxt = '0;
            w_dir_nxt  = DIR_UP;
        end else begin
            case (r_mode)
                MODE_OFF: w_duty_nxt = '0;
                MODE_ON:  w_duty_nxt = i_level;
                MODE_BLINK: begin
                    if (i_step) begin
                        if (r_dir == DIR_UP) begin
                            w_duty_nxt = i_level;
                            w_dir_nxt  = DIR_DOWN;
                        end else begin
                            w_duty_nxt = '0;
                            w_dir_nxt  = DIR_UP;
                        end
                    end
                end
                MODE_BREATHE: begin
                    if (i_step) begin
                        if (r_dir == DIR_UP) begin
                            // Clamp covers a level lowered below the current duty.
                            if (r_duty >= i_level) begin
                                w_duty_nxt = i_level;
                                w_dir_nxt  = DIR_DOWN;
                            end else begin
                                w_duty_nxt = r_duty + 1'b1;
                            end
                        end else if (r_duty == '0) begin
                            w_dir_nxt = DIR_UP;
                        end else begin
                            w_duty_nxt = r_duty - 1'b1;
                        end
                    end
                end
                default: w_duty_nxt = r_duty;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mode <= MODE_OFF;
            r_duty <= '0;
            r_dir  <= DIR_UP;
            r_led  <= 1'b0;
        end else begin
            if (i_period_end) begin
                r_mode <= w_mode_in;
                r_duty <= w_duty_nxt;
                r_dir  <= w_dir_nxt;
            end
            r_led <= i_en & (i_pwm < r_duty);
        end
    end

    assign o_led = r_led;

endmodule : led_fader_chan
`default_nettype wire

// File: rtl/led_fader.sv
`default_nettype none
// ============================================================================
// Module  : led_fader
// Brief   : Multi-channel LED driver with shared PWM timebase and step divider.
// Revision: 1.0 - initial release
// ============================================================================
module led_fader
    import led_fader_pkg::*;
#(
    parameter int P_CHANNELS = 3,
    parameter int P_PWM_BITS = 8,
    parameter int P_DIV_BITS = 16
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic                             i_en,
    input  logic [P_DIV_BITS-1:0]            i_div,
    input  logic [2*P_CHANNELS-1:0]          i_mode,
    input  logic [P_PWM_BITS*P_CHANNELS-1:0] i_level,
    output logic [P_CHANNELS-1:0]            o_led,
    output logic                             o_step
);

    localparam logic [P_PWM_BITS-1:0] c_pwm_max = '1;

    logic [P_PWM_BITS-1:0] r_pwm;
    logic [P_DIV_BITS-1:0] r_div;
    logic                  r_step;

    logic                  w_period_end;
    logic                  w_step;

    // Gating with i_en freezes the whole timebase, so channels hold too.
    assign w_period_end = i_en & (r_pwm == c_pwm_max);
    assign w_step       = w_period_end & (r_div == i_div);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pwm  <= '0;
            r_div  <= '0;
            r_step <= 1'b0;
        end else begin
            r_step <= w_step;
            if (i_en) begin
                r_pwm <= r_pwm + 1'b1;
            end
            if (w_period_end) begin
                r_div <= (r_div == i_div) ? '0 : r_div + 1'b1;
            end
        end
    end

    assign o_step = r_step;

    for (genvar c = 0; c < P_CHANNELS; c++) begin : g_chan
        led_fader_chan #(
            .P_PWM_BITS (P_PWM_BITS)
        ) u_chan (
            .i_clk        (i_clk),
            .i_rst_n      (i_rst_n),
            .i_period_end (w_period_end),
            .i_step       (w_step),
            .i_pwm        (r_pwm),
            .i_mode       (i_mode[2*c +: 2]),
            .i_level      (i_level[P_PWM_BITS*c +: P_PWM_BITS]),
            .i_en         (i_en),
            .o_led        (o_led[c])
        );
    end

endmodule : led_fader
`default_nettype wire

// File: tb/tb_led_fader.sv
`default_nettype none
// ============================================================================
// Module  : tb_led_fader
// Brief   : Scoreboard bench: per-step LED on-counts and step spacing.
// Revision: 1.0 - initial release
// ============================================================================
module tb_led_fader;
    import led_fader_pkg::*;

    localparam int P_CH  = 3;
    localparam int P_PWM = 4;
    localparam int P_DIV = 16;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic              en    = 1'b0;
    logic [P_DIV-1:0]  div   = '0;
    logic [2*P_CH-1:0] mode  = '0;
    logic [P_PWM*P_CH-1:0] level = '0;
    logic [P_CH-1:0]   led;
    logic              step;

    int checks = 0;
    int errors = 0;

    // One record per o_step pulse: on-cycles per channel since the previous
    // pulse, and the pulse spacing (0 = first pulse after reset, not checked).
    typedef struct packed {
        logic [7:0] gap;
        logic [7:0] c0;
        logic [7:0] c1;
        logic [7:0] c2;
    } rec_t;

    rec_t exp_q[$];

    led_fader #(
        .P_CHANNELS (P_CH),
        .P_PWM_BITS (P_PWM),
        .P_DIV_BITS (P_DIV)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_en    (en),
        .i_div   (div),
        .i_mode  (mode),
        .i_level (level),
        .o_led   (led),
        .o_step  (step)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int gap, input int c0, input int c1, input int c2);
        rec_t r;
        r.gap = 8'(gap);
        r.c0  = 8'(c0);
        r.c1  = 8'(c1);
        r.c2  = 8'(c2);
        exp_q.push_back(r);
    endtask

    task automatic set_ch(input int c, input mode_e m, input int l);
        mode[2*c +: 2]      = m;
        level[P_PWM*c +: P_PWM] = 4'(l);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({name, "_outstanding"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Monitor: accumulate o_led samples, score a record on every o_step.
    initial begin : monitor
        int   acc0, acc1, acc2, cyc, prev;
        bit   first;
        rec_t r;
        acc0 = 0; acc1 = 0; acc2 = 0; cyc = 0; prev = 0; first = 1'b1;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                acc0 = 0; acc1 = 0; acc2 = 0;
                first = 1'b1;
            end else begin
                acc0 += int'(led[0]);
                acc1 += int'(led[1]);
                acc2 += int'(led[2]);
                if (step) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_step: pulse at cycle %0d, none expected", cyc);
                    end else begin
                        r = exp_q.pop_front();
                        if (!first) check("step_gap", cyc - prev, int'(r.gap));
                        check("led0_on_count", acc0, int'(r.c0));
                        check("led1_on_count", acc1, int'(r.c1));
                        check("led2_on_count", acc2, int'(r.c2));
                    end
                    prev  = cyc;
                    first = 1'b0;
                    acc0 = 0; acc1 = 0; acc2 = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        en = 1'b1;
        set_ch(0, MODE_ON, 4);
        repeat (3) @(negedge clk);
        check("reset_led", int'(led), 0);
        check("reset_step", int'(step), 0);
        #2 rst_n = 1'b1;

        // ON level 4, step every period.
        push(0, 0, 0, 0);
        push(16, 0, 0, 0);
        push(16, 4, 0, 0);
        push(16, 4, 0, 0);
        drain("on_level4");

        // ch0 breathe level 3, ch1 on level 15.
        set_ch(0, MODE_BREATHE, 3);
        set_ch(1, MODE_ON, 15);
        push(16, 4, 0, 0);
        push(16, 0, 0, 0);
        push(16, 1, 15, 0);
        push(16, 2, 15, 0);
        push(16, 3, 15, 0);
        push(16, 3, 15, 0);
        push(16, 2, 15, 0);
        push(16, 1, 15, 0);
        push(16, 0, 15, 0);
        push(16, 0, 15, 0);
        push(16, 1, 15, 0);
        push(16, 2, 15, 0);
        drain("breathe_level3");

        // Asynchronous reset mid-period while both channels are lit.
        repeat (3) @(negedge clk);
        check("pre_reset_led", int'(led), 3);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_led", int'(led), 0);
        check("async_reset_step", int'(step), 0);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b1;
        push(0, 0, 0, 0);
        push(16, 0, 0, 0);
        push(16, 1, 15, 0);
        push(16, 2, 15, 0);
        drain("post_reset");

        // Divider 1: steps every 32 cycles; ch1 blink 15, ch2 on 8.
        div = 16'd1;
        set_ch(0, MODE_OFF, 3);
        set_ch(1, MODE_BLINK, 15);
        set_ch(2, MODE_ON, 8);
        push(32, 3, 15, 0);
        push(32, 0, 30, 16);
        push(32, 0, 0, 16);
        push(32, 0, 30, 16);
        drain("blink_div1");

        // Move into the second period so ch2's change lands on a step.
        repeat (16) @(negedge clk);
        set_ch(2, MODE_BREATHE, 8);
        push(32, 0, 0, 16);
        push(32, 0, 30, 0);
        push(32, 0, 0, 2);
        push(32, 0, 30, 4);
        drain("mode_change_on_step");

        // ch0 breathe level 15 up to duty 10.
        div = '0;
        set_ch(0, MODE_BREATHE, 15);
        set_ch(1, MODE_OFF, 15);
        set_ch(2, MODE_OFF, 8);
        push(16, 0, 0, 3);
        for (int k = 2; k <= 11; k++) push(16, k - 2, 0, 0);
        drain("breathe_ramp");

        // Level lowered below the rising duty: clamp to 5 and turn down.
        set_ch(0, MODE_BREATHE, 5);
        push(16, 10, 0, 0);
        drain("level_lowered");

        // Enable low for 40 cycles mid-period; state holds and resumes.
        push(56, 5, 0, 0);
        push(16, 4, 0, 0);
        repeat (3) @(negedge clk);
        #1 en = 1'b0;
        @(negedge clk);
        #1;
        check("en_low_led", int'(led), 0);
        check("en_low_step", int'(step), 0);
        repeat (39) @(negedge clk);
        #1 en = 1'b1;
        drain("enable_hold");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_led_fader
`default_nettype wire

// File: doc/led_fader.md
# led_fader

Parametrised multi-channel LED driver for the board RGB outputs. It generalises the fixed per-colour counter-bit blinker into three parts:
- a shared PWM timebase;
- a programmable step divider;
- per-channel brightness control with four modes: off, steady, blink and breathe (triangular fade).

It sits between the top-level control logic and the LED pins, one output bit per channel.

## Interface
- P_CHANNELS, 3, number of LED channels
- P_PWM_BITS, 8, PWM resolution; period = 2^P_PWM_BITS clocks
- P_DIV_BITS, 16, width of the step divider

- i_clk  in  1  system clock
- i_rst_n  in  1  reset; one clock, asynchronous, active-low
- i_en  in  1  global enable
- i_div  in  P_DIV_BITS  steps occur every (i_div+1) PWM periods
- i_mode  in  2*P_CHANNELS  per-channel mode, channel c at [2c+1:2c]: 00 off, 01 on, 10 blink, 11 breathe
- i_level  in  P_PWM_BITS*P_CHANNELS  per-channel peak duty, channel c at [P_PWM_BITS*c +: P_PWM_BITS]
- o_led  out  P_CHANNELS  LED drive, active-high
- o_step  out  1  one-cycle pulse per step

## Operation
- **PWM counter.** r_pwm free-runs 0..2^P_PWM_BITS-1 and wraps to 0. A period end is the cycle where r_pwm is at its maximum.
- **Step divider.**
  - r_div increments at each period end.
  - At a period end with r_div == i_div, r_div clears and a step occurs.
  - i_div = 0 gives a step every period.
- **Duty register timing.** Each channel's r_duty (P_PWM_BITS) and r_dir (UP/DOWN) change only at period ends. Updates are therefore glitch-free.
- **Mode latch.**
  - At each period end, each channel compares i_mode with its latched mode.
  - On a difference: latch the new mode, set r_duty = 0 and r_dir = UP. This applies to every mode; off/on then continue normally from the next period end.
  - On a match, the rules below apply.
- **Off:** r_duty = 0 at every period end.
- **On:** r_duty = i_level at every period end.
- **Blink,** on each step:
  - r_dir = UP: r_duty = i_level, r_dir = DOWN.
  - r_dir = DOWN: r_duty = 0, r_dir = UP.
- **Breathe,** on each step:
  - UP with r_duty >= i_level: r_duty = i_level, r_dir = DOWN. This clamps if the level was lowered.
  - UP otherwise: r_duty + 1.
  - DOWN with r_duty == 0: r_dir = UP, r_duty stays 0.
  - DOWN otherwise: r_duty - 1.
- **Output:** o_led[c] <= i_en & (r_pwm < r_duty[c]), registered.
  - Duty 0 → constantly off.
  - Duty 2^P-1 → high (2^P-1) of 2^P cycles.
- **i_en low:**
  - r_pwm, r_div, duty and dir hold.
  - o_led = 0 from the next edge, o_step = 0.
  - Resuming continues from the held state.
- **Arithmetic:** all compares unsigned. No duty overflow is possible because of the clamp at i_level.

## Timing
- Reset values, all applied asynchronously on i_rst_n low: r_pwm 0, r_div 0, r_duty 0, r_dir UP, latched mode 00, o_led 0, o_step 0.
- After release, the first PWM period starts on the first enabled edge.
- o_led has 1 cycle of latency from r_pwm/r_duty.
- o_step is high for one cycle, on the cycle after the step period end. It is co-timed with the first cycle at the new duty.
- Step interval: (i_div+1)·2^P_PWM_BITS clocks.
- Breathe full cycle: 2·(level+1) steps. Blink full cycle: 2 steps.
- i_mode/i_level are sampled only at period ends. Changes elsewhere are invisible until then.
- A mode change at the same period end as a step: the mode latch wins and the step rule is skipped for that channel.

## Structure
- Package led_fader_pkg:
  - mode constants MODE_OFF/ON/BLINK/BREATHE (2 bits);
  - direction constants DIR_UP/DIR_DOWN.
- Top led_fader holds:
  - the PWM counter and step divider;
  - a generate loop of P_CHANNELS instances.
- Sub-module led_fader_chan holds:
  - the mode latch, r_duty and r_dir;
  - the output compare and register.
- Its inputs are period_end, step, r_pwm, mode, level and en.

## Test plan
All scenarios use P_PWM_BITS=4, P_CHANNELS=3.
- Reset: assert i_rst_n low mid-breathe for 5 cycles → o_led=000 and o_step=0 without a clock edge; after release the duty sequence restarts from 0.
- ON, level 4, i_div 0 → o_led[0] high exactly 4 of every 16 cycles; o_step pulses every 16 cycles.
- Divider, i_div=1 → o_step pulses exactly every 32 cycles; no o_led change between steps in blink.
- Breathe, level 3 → per-period duty 1,2,3,3,2,1,0,0,1… (8-step cycle).
- Blink, level 15 → o_led[1] high 15 of 16 cycles and 0 of 16 cycles on alternate steps. Simultaneously, a mode change on ch2 at a step boundary → ch2 duty 0, dir UP.
- Breathe at duty 10 UP with level lowered to 5 → next step duty 5, DOWN. Then i_en low for 40 cycles → o_led=000, duty held at 5; resumes unchanged.
